// File: rtl/debug_pkg.sv
// Shared constants, state encoding and report payload for the UART debug unit.
package debug_pkg;

  localparam int unsigned IMEM_DEPTH   = 64;
  localparam int unsigned ADDR_W       = $clog2(IMEM_DEPTH);
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned REPORT_BYTES = 12;
  localparam int unsigned RPT_IDX_W    = $clog2(REPORT_BYTES);

  localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_STEP = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_SEND
  } state_t;

  // Last member is least significant, so PC goes out on the wire first.
  typedef struct packed {
    logic [WORD_W-1:0] xsum;
    logic [WORD_W-1:0] cnt;
    logic [WORD_W-1:0] pc;
  } report_t;

endpackage

// File: rtl/debug_if.sv
// UART-side signal bundle; master is the UART pair, slave is the debug unit.
interface debug_if;

  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] i_data;
  logic [7:0] o_data_send;
  logic       o_tx_start;

  modport master (
    output i_rx_done, i_tx_done, i_data,
    input  o_data_send, o_tx_start
  );

  modport slave (
    input  i_rx_done, i_tx_done, i_data,
    output o_data_send, o_tx_start
  );

endinterface

// File: rtl/debug_imem.sv
// Instruction word store: synchronous write, asynchronous read, reset fills with the halt word.
module debug_imem
  import debug_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(IMEM_DEPTH); i++) mem[i] <= HALT_WORD;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/debug_top.sv
// UART-driven debug unit: loads program words, runs/steps a PC to the halt word, reports status.
module debug_top
  import debug_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  debug_if.slave  bus
);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [WORD_W-1:0]      cnt_q, cnt_d;
  logic [WORD_W-1:0]      xsum_q, xsum_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [RPT_IDX_W-1:0]   tx_idx_q, tx_idx_d;
  logic                   tx_wait_q, tx_wait_d;
  logic [BYTE_W-1:0]      data_send_q, data_send_d;
  logic                   tx_start_q, tx_start_d;
  logic                   rx_done_q;

  logic                   rx_accept_c;
  logic                   imem_we_c;
  logic [WORD_W-1:0]      imem_wdata_c;
  logic [WORD_W-1:0]      imem_rdata_c;
  logic                   halt_c;
  logic [ADDR_W-1:0]      pc_inc_c;
  report_t                rpt_c;
  logic [REPORT_BYTES*BYTE_W-1:0] rpt_bits_c;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  debug_imem u_imem (
    .clk     (clk),
    .rst     (rst),
    .we      (imem_we_c),
    .waddr   (ptr_q),
    .wdata   (imem_wdata_c),
    .raddr   (pc_q),
    .rdata_c (imem_rdata_c)
  );

  assign rx_accept_c  = bus.i_rx_done & ~rx_done_q;
  // New byte enters at the top so the first byte ends up in bits [7:0].
  assign imem_wdata_c = {bus.i_data, word_q[WORD_W-1:BYTE_W]};
  // A PC parked on the last location is treated as halted so it can never wrap.
  assign halt_c       = (imem_rdata_c == HALT_WORD) || (pc_q == LAST_ADDR);
  assign pc_inc_c     = pc_q + ADDR_W'(1);
  assign rpt_c        = '{xsum: xsum_q, cnt: cnt_q, pc: WORD_W'(pc_q)};
  assign rpt_bits_c   = rpt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      xsum_q      <= '0;
      ptr_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      tx_idx_q    <= '0;
      tx_wait_q   <= 1'b0;
      data_send_q <= '0;
      tx_start_q  <= 1'b0;
      rx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      xsum_q      <= xsum_d;
      ptr_q       <= ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      tx_idx_q    <= tx_idx_d;
      tx_wait_q   <= tx_wait_d;
      data_send_q <= data_send_d;
      tx_start_q  <= tx_start_d;
      rx_done_q   <= bus.i_rx_done;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    xsum_d      = xsum_q;
    ptr_d       = ptr_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    tx_idx_d    = tx_idx_q;
    tx_wait_d   = tx_wait_q;
    data_send_d = data_send_q;
    tx_start_d  = 1'b0;
    imem_we_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_accept_c) begin
          case (bus.i_data)
            CMD_LOAD: begin
              state_d    = ST_LOAD;
              pc_d       = '0;
              cnt_d      = '0;
              xsum_d     = '0;
              ptr_d      = '0;
              byte_cnt_d = '0;
            end
            CMD_STEP: state_d = ST_STEP;
            CMD_RUN:  state_d = ST_RUN;
            default:  state_d = ST_IDLE;
          endcase
        end
      end

      ST_LOAD: begin
        if (rx_accept_c) begin
          word_d     = imem_wdata_c;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_c = 1'b1;
            ptr_d     = ptr_q + ADDR_W'(1);
            if (imem_wdata_c == HALT_WORD || ptr_q == LAST_ADDR) state_d = ST_IDLE;
          end
        end
      end

      ST_RUN, ST_STEP: begin
        if (!halt_c) begin
          pc_d   = pc_inc_c;
          cnt_d  = cnt_q + WORD_W'(1);
          xsum_d = xsum_q ^ imem_rdata_c;
        end
        if (halt_c || pc_inc_c == LAST_ADDR || state_q == ST_STEP) begin
          state_d   = ST_SEND;
          tx_idx_d  = '0;
          tx_wait_d = 1'b0;
        end
      end

      ST_SEND: begin
        // Issue phase pulses the byte; wait phase holds until the UART reports done.
        if (!tx_wait_q) begin
          tx_start_d  = 1'b1;
          data_send_d = BYTE_W'(rpt_bits_c >> {tx_idx_q, 3'b000});
          tx_wait_d   = 1'b1;
        end else if (bus.i_tx_done) begin
          tx_wait_d = 1'b0;
          if (tx_idx_q == RPT_IDX_W'(REPORT_BYTES - 1)) state_d = ST_IDLE;
          else                                          tx_idx_d = tx_idx_q + RPT_IDX_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_data_send = data_send_q;
  assign bus.o_tx_start  = tx_start_q;

endmodule

// File: tb/tb_debug_top.sv
// Directed self-checking bench for debug_top: load, run, step, strobe edge, tx back-pressure, reset abort.
module tb_debug_top;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_got;
  int   first_cyc;
  int   last_cyc;
  logic [7:0] rpt [12];

  debug_if bus ();

  debug_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_data    = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  // Records tx pulses into rpt[first..stop-1] within a cycle budget.
  task automatic collect(input int first, input int stop, input int budget);
    n_got = first;
    for (int c = 0; c < budget && n_got < stop; c++) begin
      @(negedge clk);
      if (bus.o_tx_start) begin
        if (n_got == 0) first_cyc = cyc;
        last_cyc   = cyc;
        rpt[n_got] = bus.o_data_send;
        n_got++;
      end
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int extra = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.o_tx_start) extra++;
    end
    chk(tag, 32'(extra), 32'd0);
  endtask

  task automatic chk_report(input string tag, input logic [31:0] pc,
                            input logic [31:0] cnt, input logic [31:0] xsum);
    logic [95:0] exp_bits;
    exp_bits = {xsum, cnt, pc};
    chk({tag, "_n"}, 32'(n_got), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(rpt[i]), 32'(exp_bits[i*8 +: 8]));
  endtask

  initial begin
    int bad_start;
    int bad_data;
    logic [7:0] b0;

    rst           = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b1;
    bus.i_data    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
    chk("rst_data", 32'(bus.o_data_send), 32'd0);
    rst = 1'b0;

    // T1: run on empty memory reports zeros, one byte every 2 cycles
    send_byte(8'h03);
    collect(0, 12, 200);
    chk_report("t1", 32'd0, 32'd0, 32'd0);
    chk("t1_span", 32'(last_cyc - first_cyc), 32'd22);
    quiet("t1_extra", 20);

    // T2: load two words and the halt word, then run
    send_byte(8'h01);
    load_word(32'h0403_0201);
    load_word(32'h20C0_4080);
    load_word(32'hFFFF_FFFF);
    send_byte(8'h03);
    collect(0, 12, 200);
    chk_report("t2", 32'd2, 32'd2, 32'h24C3_4281);
    quiet("t2_extra", 10);

    // T3: reload and single-step three times
    send_byte(8'h01);
    load_word(32'h0403_0201);
    load_word(32'h20C0_4080);
    load_word(32'hFFFF_FFFF);
    send_byte(8'h02);
    collect(0, 12, 200);
    chk_report("t3s1", 32'd1, 32'd1, 32'h0403_0201);
    send_byte(8'h02);
    collect(0, 12, 200);
    chk_report("t3s2", 32'd2, 32'd2, 32'h24C3_4281);
    send_byte(8'h02);
    collect(0, 12, 200);
    chk_report("t3s3", 32'd2, 32'd2, 32'h24C3_4281);

    // T4: strobe held high for 5 cycles gives a single run
    fork
      begin
        @(negedge clk);
        bus.i_data    = 8'h03;
        bus.i_rx_done = 1'b1;
        repeat (5) @(negedge clk);
        bus.i_rx_done = 1'b0;
      end
      collect(0, 12, 200);
    join
    chk_report("t4", 32'd2, 32'd2, 32'h24C3_4281);
    quiet("t4_extra", 40);

    // T5: tx done held low stalls after the first byte
    send_byte(8'h01);
    load_word(32'h1122_3344);
    load_word(32'hFFFF_FFFF);
    bus.i_tx_done = 1'b0;
    send_byte(8'h03);
    collect(0, 1, 100);
    chk("t5_first", 32'(n_got), 32'd1);
    b0        = rpt[0];
    bad_start = 0;
    bad_data  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_tx_start) bad_start++;
      if (bus.o_data_send !== b0) bad_data++;
    end
    chk("t5_stall_start", 32'(bad_start), 32'd0);
    chk("t5_stall_data", 32'(bad_data), 32'd0);
    bus.i_tx_done = 1'b1;
    collect(1, 12, 200);
    chk_report("t5", 32'd1, 32'd1, 32'h1122_3344);

    // Fill every location: load ends at the last one, run stops with PC on it
    send_byte(8'h01);
    for (int w = 0; w < 64; w++) load_word(32'h0000_0001);
    send_byte(8'h03);
    collect(0, 12, 400);
    chk_report("full_run", 32'd63, 32'd63, 32'd1);
    send_byte(8'h03);
    collect(0, 12, 200);
    chk_report("full_rerun", 32'd63, 32'd63, 32'd1);

    // T6: reset during the fifth byte aborts, then everything is cleared
    send_byte(8'h03);
    collect(0, 5, 200);
    chk("t6_pre", 32'(n_got), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_tx_start", 32'(bus.o_tx_start), 32'd0);
    chk("t6_data", 32'(bus.o_data_send), 32'd0);
    rst = 1'b0;
    quiet("t6_abort", 10);
    send_byte(8'h03);
    collect(0, 12, 200);
    chk_report("t6", 32'd0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
